// File: rtl/pwm_pkg.sv
// pwm_pkg: shared definitions for the PWM LED drivers and the PWM duty meter.
//   DUTY_BITS : duty resolution shared by the drivers and the meter
//   state_t   : duty meter FSM states
package pwm_pkg;

    localparam int DUTY_BITS = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_HIGH = 2'd2,
        ST_LOW  = 2'd3
    } state_t;

endpackage

// File: rtl/pwm_frac_div.sv
// pwm_frac_div: sequential restoring divider, one quotient bit per cycle.
// Computes quot = floor(num * 2^DUTY_BITS / den), assuming num < den.
//   clk, rst_n : clock, async active-low reset
//   start      : load num/den and begin (ignored when abort is high)
//   abort      : drop any division in progress
//   num, den   : operands, sampled on start
//   busy       : division in progress
//   done       : high during the final iteration cycle; quot is valid then
//   quot       : final quotient (meaningful only while done is high)
module pwm_frac_div
    import pwm_pkg::*;
#(
    parameter int DUTY_BITS = pwm_pkg::DUTY_BITS,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [CNT_W-1:0]     num,
    input  logic [CNT_W-1:0]     den,
    output logic                 busy,
    output logic                 done,
    output logic [DUTY_BITS-1:0] quot
);

    localparam int CW = $clog2(DUTY_BITS + 1);

    logic [CNT_W-1:0]     rem_q, rem_d;
    logic [CNT_W-1:0]     den_q, den_d;
    // Holds the bits produced so far; the final bit is appended combinationally.
    logic [DUTY_BITS-2:0] quot_q, quot_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 busy_q, busy_d;

    logic [CNT_W:0]       shifted;
    logic [CNT_W-1:0]     diff;
    logic                 ge;
    logic [DUTY_BITS-1:0] quot_step;

    always_comb begin
        shifted   = {rem_q, 1'b0};
        ge        = (shifted >= {1'b0, den_q});
        // Remainder stays below den, so the modular difference is exact.
        diff      = shifted[CNT_W-1:0] - den_q;
        quot_step = {quot_q, ge};

        rem_d  = rem_q;
        den_d  = den_q;
        quot_d = quot_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (abort) begin
            busy_d = 1'b0;
        end else if (start) begin
            rem_d  = num;
            den_d  = den;
            quot_d = '0;
            cnt_d  = CW'(DUTY_BITS);
            busy_d = 1'b1;
        end else if (busy_q) begin
            rem_d  = ge ? diff : shifted[CNT_W-1:0];
            quot_d = quot_step[DUTY_BITS-2:0];
            cnt_d  = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q  <= '0;
            den_q  <= '0;
            quot_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            den_q  <= den_d;
            quot_q <= quot_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;
    assign done = busy_q && (cnt_q == CW'(1));
    assign quot = quot_step;

endmodule

// File: rtl/pwm_duty_meter.sv
// pwm_duty_meter: measures high time and period of an asynchronous PWM input
// and reports duty = high * 2^DUTY_BITS / period. Lines without edges for
// TIMEOUT_CYCLES are reported as stuck (duty all ones or zero).
//   clk, rst_n : clock, async active-low reset
//   enable     : measurement enable; low returns the FSM to IDLE
//   pwm_in     : asynchronous PWM input
//   duty       : last duty result
//   high_time  : last measured high time (clk cycles)
//   period     : last measured period (clk cycles)
//   valid      : 1-cycle strobe, results updated
//   stuck      : last result came from a timeout
//   overrun    : 1-cycle strobe, a completed period was dropped (divider busy)
module pwm_duty_meter
    import pwm_pkg::*;
#(
    parameter int DUTY_BITS      = pwm_pkg::DUTY_BITS,
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 pwm_in,
    output logic [DUTY_BITS-1:0] duty,
    output logic [CNT_W-1:0]     high_time,
    output logic [CNT_W-1:0]     period,
    output logic                 valid,
    output logic                 stuck,
    output logic                 overrun
);

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT_CYCLES);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    logic s1_q, s2_q, s3_q;
    logic rise, fall, timeout;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     hcnt_q, hcnt_d, pcnt_q, pcnt_d;
    logic [CNT_W-1:0]     meas_h_q, meas_h_d, meas_p_q, meas_p_d;
    logic [DUTY_BITS-1:0] duty_q, duty_d;
    logic [CNT_W-1:0]     high_time_q, high_time_d, period_q, period_d;
    logic                 valid_q, valid_d, stuck_q, stuck_d, overrun_q, overrun_d;

    logic                 div_start, div_abort, div_busy, div_done;
    logic [DUTY_BITS-1:0] div_quot;

    pwm_frac_div #(.DUTY_BITS(DUTY_BITS), .CNT_W(CNT_W)) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .start (div_start),
        .abort (div_abort),
        .num   (hcnt_q),
        .den   (pcnt_q),
        .busy  (div_busy),
        .done  (div_done),
        .quot  (div_quot)
    );

    assign rise = s2_q & ~s3_q;
    assign fall = ~s2_q & s3_q;
    // An edge in the same cycle always beats the timeout.
    assign timeout = (pcnt_q == TIMEOUT_CNT) &&
                     (((state_q == ST_HIGH) && !fall) || ((state_q == ST_LOW) && !rise));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next state
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_ARM;
                ST_ARM:  if (rise) state_d = ST_HIGH;
                ST_HIGH: if (fall) state_d = ST_LOW;  else if (timeout) state_d = ST_ARM;
                ST_LOW:  if (rise) state_d = ST_HIGH; else if (timeout) state_d = ST_ARM;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Counters, divider control and result registers
    always_comb begin
        hcnt_d      = hcnt_q;
        pcnt_d      = pcnt_q;
        meas_h_d    = meas_h_q;
        meas_p_d    = meas_p_q;
        duty_d      = duty_q;
        high_time_d = high_time_q;
        period_d    = period_q;
        stuck_d     = stuck_q;
        valid_d     = 1'b0;
        overrun_d   = 1'b0;
        div_start   = 1'b0;
        div_abort   = 1'b0;

        if (!enable) begin
            hcnt_d    = '0;
            pcnt_d    = '0;
            div_abort = 1'b1;
        end else begin
            if (div_done) begin
                duty_d      = div_quot;
                high_time_d = meas_h_q;
                period_d    = meas_p_q;
                stuck_d     = 1'b0;
                valid_d     = 1'b1;
            end
            case (state_q)
                ST_ARM: begin
                    if (rise) begin
                        hcnt_d = CNT_W'(1);
                        pcnt_d = CNT_W'(1);
                    end
                end
                ST_HIGH: begin
                    if (fall) begin
                        pcnt_d = sat_inc(pcnt_q);
                    end else if (!timeout) begin
                        hcnt_d = sat_inc(hcnt_q);
                        pcnt_d = sat_inc(pcnt_q);
                    end
                end
                ST_LOW: begin
                    if (rise) begin
                        if (!div_busy) begin
                            div_start = 1'b1;
                            meas_h_d  = hcnt_q;
                            meas_p_d  = pcnt_q;
                        end else begin
                            overrun_d = 1'b1;
                        end
                        hcnt_d = CNT_W'(1);
                        pcnt_d = CNT_W'(1);
                    end else if (!timeout) begin
                        pcnt_d = sat_inc(pcnt_q);
                    end
                end
                default: ;
            endcase
            // Stuck report overrides any division finishing in the same cycle.
            if (timeout) begin
                duty_d      = (state_q == ST_HIGH) ? '1 : '0;
                high_time_d = '0;
                period_d    = '0;
                stuck_d     = 1'b1;
                valid_d     = 1'b1;
                div_abort   = 1'b1;
                hcnt_d      = '0;
                pcnt_d      = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            s3_q        <= 1'b0;
            hcnt_q      <= '0;
            pcnt_q      <= '0;
            meas_h_q    <= '0;
            meas_p_q    <= '0;
            duty_q      <= '0;
            high_time_q <= '0;
            period_q    <= '0;
            valid_q     <= 1'b0;
            stuck_q     <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            s1_q        <= pwm_in;
            s2_q        <= s1_q;
            s3_q        <= s2_q;
            hcnt_q      <= hcnt_d;
            pcnt_q      <= pcnt_d;
            meas_h_q    <= meas_h_d;
            meas_p_q    <= meas_p_d;
            duty_q      <= duty_d;
            high_time_q <= high_time_d;
            period_q    <= period_d;
            valid_q     <= valid_d;
            stuck_q     <= stuck_d;
            overrun_q   <= overrun_d;
        end
    end

    assign duty      = duty_q;
    assign high_time = high_time_q;
    assign period    = period_q;
    assign stuck     = stuck_q;
    // Strobes are suppressed as soon as enable drops.
    assign valid     = valid_q & enable;
    assign overrun   = overrun_q & enable;

endmodule
